// File: rtl/serial_addsub_digit.sv
// Digit-serial add/subtract, DW bits per beat, LSB digit first; optional length check via SERIAL_ADDSUB_LEN_CHECK_EN.
// Latency: 1 cycle from accepted beat to registered result digit and flags.
// Backpressure: none; every vld beat is accepted, and idle cycles between beats are allowed.
module serial_addsub_digit #(
    parameter int DW        = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          last,
    input  logic          sub,
    output logic          out_vld,
    output logic [DW-1:0] out_sum,
    output logic          out_last,
    output logic          out_cout,
    output logic          out_ovf
`ifdef SERIAL_ADDSUB_LEN_CHECK_EN
    ,
    output logic          out_err
`endif
);

    // Reject nonsensical parameterisations at elaboration
    if (DW < 1 || MAX_BEATS < 1) begin : g_param_chk
        $error("serial_addsub_digit: DW and MAX_BEATS must be >= 1");
    end

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          carry_q, carry_d;
    logic          mode_q, mode_d;
    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_sum_q, out_sum_d;
    logic          out_last_q, out_last_d;
    logic          out_cout_q, out_cout_d;
    logic          out_ovf_q, out_ovf_d;

    logic          eff_mode;
    logic          cin;
    logic [DW-1:0] bb;
    logic [DW:0]   full;
    logic [DW-1:0] s;
    logic          c_out;
    logic          c_msb;

`ifdef SERIAL_ADDSUB_LEN_CHECK_EN
    localparam int CW = $clog2(MAX_BEATS + 1);
    // cnt holds the number of beats already accepted in this packet, saturating at MAX_BEATS
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Digit arithmetic and next-state computation for one beat
    always_comb begin
        eff_mode = (state_q == FIRST) ? sub : mode_q;
        cin      = (state_q == FIRST) ? sub : carry_q;
        bb       = b ^ {DW{eff_mode}};
        full     = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, cin};
        s        = full[DW-1:0];
        c_out    = full[DW];
        // carry into the MSB column; differs from carry out exactly on signed overflow
        c_msb    = a[DW-1] ^ bb[DW-1] ^ s[DW-1];

        state_d    = state_q;
        carry_d    = carry_q;
        mode_d     = mode_q;
        out_vld_d  = 1'b0;
        out_sum_d  = out_sum_q;
        out_last_d = 1'b0;
        out_cout_d = 1'b0;
        out_ovf_d  = 1'b0;
`ifdef SERIAL_ADDSUB_LEN_CHECK_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif

        if (vld) begin
            out_vld_d  = 1'b1;
            out_sum_d  = s;
            out_last_d = last;
            out_cout_d = last & c_out;
            out_ovf_d  = last & (c_msb ^ c_out);
            carry_d    = c_out;
            if (state_q == FIRST && !last) begin
                mode_d  = sub;
                state_d = MID;
            end
            if (last) begin
                state_d = FIRST;
                carry_d = 1'b0;
            end
`ifdef SERIAL_ADDSUB_LEN_CHECK_EN
            // a sticky error from the previous packet is dropped when a new packet starts
            if (state_q == FIRST) begin
                err_d = 1'b0;
            end
            if (cnt_q == CW'(MAX_BEATS) && !last) begin
                err_d = 1'b1;
            end
            if (last) begin
                cnt_d = '0;
            end else if (cnt_q != CW'(MAX_BEATS)) begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end
    end

    // State, carry, mode and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FIRST;
            carry_q    <= 1'b0;
            mode_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            out_sum_q  <= '0;
            out_last_q <= 1'b0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_LEN_CHECK_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            carry_q    <= carry_d;
            mode_q     <= mode_d;
            out_vld_q  <= out_vld_d;
            out_sum_q  <= out_sum_d;
            out_last_q <= out_last_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
`ifdef SERIAL_ADDSUB_LEN_CHECK_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign out_vld  = out_vld_q;
    assign out_sum  = out_sum_q;
    assign out_last = out_last_q;
    assign out_cout = out_cout_q;
    assign out_ovf  = out_ovf_q;
`ifdef SERIAL_ADDSUB_LEN_CHECK_EN
    assign out_err  = err_q;
`endif

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
- Digit-serial adder/subtractor, successor of the 1-bit serial adder: processes DW bits per beat, LSB digit first, operands framed by vld/last.
- Per-packet add/subtract mode, registered outputs with valid/last, and carry-out and signed-overflow flags on the final digit.
- Sits between digit-serial operand streams and downstream serial consumers in the arithmetic datapath.

Parameters:
- DW, 4, digit width in bits per beat (>=1)
- MAX_BEATS, 16, maximum beats per packet; used only when the optional feature is compiled in

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- vld  input  1  input beat valid
- a  input  DW  operand A digit
- b  input  DW  operand B digit
- last  input  1  beat carries the most significant digit of the packet
- sub  input  1  1 = A−B, 0 = A+B; sampled on the first beat of a packet only
- out_vld  output  1  output beat valid
- out_sum  output  DW  result digit
- out_last  output  1  final result digit
- out_cout  output  1  final carry out; valid when out_vld & out_last, else 0
- out_ovf  output  1  two's-complement overflow; valid when out_vld & out_last, else 0

Behaviour:
- Reset (rst=0, async):
  - state=FIRST, carry=0, mode=0.
  - All outputs 0; out_sum=0.
- States:
  - FIRST: next valid beat starts a packet.
  - MID: inside a packet.
- Beat accepted when vld=1 at posedge clk. vld=0: no state change, carry and mode held; gaps of any length allowed mid-packet.
- Effective mode and carry-in for each accepted beat:
  - In FIRST: effective mode = sub input; carry-in = sub.
  - In MID: effective mode = latched mode; carry-in = carry register.
- Operand B: bb = b XOR {DW{effective mode}}.
- Arithmetic: {c_out, s} = a + bb + carry-in, computed at DW+1 bits.
- Carry into digit MSB: c_msb = a[DW-1] ^ bb[DW-1] ^ s[DW-1].
- Updates on an accepted beat:
  - Beat in FIRST with last=0: mode<=sub; state<=MID.
  - carry<=c_out.
  - last=1: state<=FIRST, carry<=0. A single-beat packet (first and last beat) never leaves FIRST.
- Outputs are registered, latency 1 cycle. On the edge that accepts a beat:
  - out_vld<=1, out_sum<=s, out_last<=last.
  - out_cout<=last & c_out.
  - out_ovf<=last & (c_msb ^ c_out).
- On edges without an accepted beat: out_vld, out_last, out_cout and out_ovf all <=0; out_sum holds.
- Subtract semantics: out_cout=1 means no borrow (A>=B unsigned).
- Back-to-back packets: a beat in FIRST right after a last beat uses the fresh carry-in; no bubble required.
- sub changes mid-packet are ignored.
- a/b/last/sub are don't-care when vld=0.
- Reset mid-packet aborts the packet; the next valid beat is treated as a first beat.

Optional Feature:
- Macro SERIAL_ADDSUB_LEN_CHECK_EN.
- Defined:
  - Adds output out_err (1 bit, reset 0) and a beat counter of $clog2(MAX_BEATS+1) bits.
  - Counter clears on the last beat and on reset.
  - Accepting beat number MAX_BEATS+1 without last sets out_err<=1 (registered, same latency as out_vld).
  - The counter saturates; out_err stays 1 until the packet's last beat has been output, then clears on the next accepted first beat.
  - Arithmetic is unaffected.
- Undefined: no counter, no out_err port; packets of any length are accepted.

Test Plan:
- DW=4, add, 2 beats, a=F,F, b=1,0 (A=0xFF, B=0x01) -> out_sum 0 then 0; final out_cout=1, out_ovf=0; out_vld one cycle after each beat.
- DW=4, sub=1, 1 beat, a=5, b=7 -> out_sum=E, out_last=1, out_cout=0, out_ovf=0.
- DW=4, add, 1 beat, a=7, b=1 -> out_sum=8, out_cout=0, out_ovf=1.
- DW=4, sub packet A=0x12, B=0x03 with vld gaps of 3 cycles between beats, sub toggled mid-packet -> out_sum 0xF then 0x0, out_cout=1; gaps give out_vld=0.
- Back-to-back: sub packet (A=0x10, B=0x01) immediately followed by add packet (A=0x01, B=0x01) -> 0xF, 0x0, then 0x2 with out_cout=0.
- Reset asserted asynchronously after beat 1 of a 2-beat add (a=F, b=1): outputs 0 immediately. Next single-beat add a=1, b=1 -> out_sum=2, out_cout=0 (no stale carry).
- With SERIAL_ADDSUB_LEN_CHECK_EN and MAX_BEATS=4: 5 beats without last -> out_err=1 coincident with the 5th out_vld.
